// File: rtl/gate_sweep_ctrl.sv
// Sweeps all four 2-input vectors through N_IMPL gate implementations and
// counts mismatches against the golden function chosen by i_op.
module gate_sweep_ctrl #(
    parameter int HOLD_CYCLES = 2,
    parameter int N_IMPL      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    output logic                  o_a,
    output logic                  o_b,
    input  logic [N_IMPL-1:0]     i_dut_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [3*N_IMPL-1:0]   o_err_cnt,
    output logic [1:0]            o_first_fail,
    output logic                  o_fail_valid
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_vec;
    logic [1:0]            r_op;
    logic [3:0]            r_hold;
    logic [3*N_IMPL-1:0]   r_err;
    logic [1:0]            r_first;
    logic                  r_fvalid;

    logic                  w_start_ok;
    logic                  w_golden;
    logic [N_IMPL-1:0]     w_mis;
    logic [3*N_IMPL-1:0]   w_err_next;

    assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_golden = 1'b0;
        case (r_op)
            2'b00:   w_golden = ~(r_vec[1] | r_vec[0]);
            2'b01:   w_golden = ~(r_vec[1] ^ r_vec[0]);
            2'b10:   w_golden = ~(r_vec[1] & r_vec[0]);
            default: w_golden =   r_vec[1] ^ r_vec[0];
        endcase
    end

    assign w_mis = i_dut_out ^ {N_IMPL{w_golden}};

    // Per-implementation counters saturate at 7 so a bad part never wraps to "clean".
    for (genvar gi = 0; gi < N_IMPL; gi++) begin : g_err
        assign w_err_next[3*gi +: 3] = (w_mis[gi] && r_err[3*gi +: 3] != 3'd7)
                                     ? r_err[3*gi +: 3] + 3'd1
                                     : r_err[3*gi +: 3];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = S_SETTLE;
            S_SETTLE:       if (r_hold == HOLD_LAST) w_next = S_CHECK;
            S_CHECK:        w_next = (r_vec == 2'd3) ? S_DONE : S_SETTLE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vec    <= '0;
            r_op     <= '0;
            r_hold   <= '0;
            r_err    <= '0;
            r_first  <= '0;
            r_fvalid <= 1'b0;
        end else if (w_start_ok) begin
            r_op     <= i_op;
            r_vec    <= '0;
            r_hold   <= '0;
            r_err    <= '0;
            r_first  <= '0;
            r_fvalid <= 1'b0;
        end else if (r_state == S_SETTLE) begin
            r_hold <= r_hold + 4'd1;
        end else if (r_state == S_CHECK) begin
            r_err <= w_err_next;
            if (|w_mis && !r_fvalid) begin
                r_first  <= r_vec;
                r_fvalid <= 1'b1;
            end
            // Last vector stays on a/b through DONE.
            if (r_vec != 2'd3) begin
                r_vec  <= r_vec + 2'd1;
                r_hold <= '0;
            end
        end
    end

    always_comb begin
        o_busy = (r_state == S_SETTLE) || (r_state == S_CHECK);
        o_done = (r_state == S_DONE);
        o_pass = (r_state == S_DONE) && (r_err == '0);
    end

    assign o_a          = r_vec[1];
    assign o_b          = r_vec[0];
    assign o_err_cnt    = r_err;
    assign o_first_fail = r_first;
    assign o_fail_valid = r_fvalid;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: two controllers (HOLD_CYCLES=2 and 1) driving modelled gate
// implementations whose behaviour is selected per test.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;

    logic       a, b, busy, done, pass, fvalid;
    logic [8:0] err;
    logic [1:0] ff;
    logic [2:0] dout;

    logic       a1, b1, busy1, done1, pass1, fvalid1;
    logic [8:0] err1;
    logic [1:0] ff1;
    logic [2:0] dout1;

    // 0 NOR, 1 XNOR, 2 NAND, 3 XOR, 4 stuck-0, 5 stuck-1
    logic [2:0] fn [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic gf(input logic [2:0] c, input logic x, input logic y);
        case (c)
            3'd0:    return ~(x | y);
            3'd1:    return ~(x ^ y);
            3'd2:    return ~(x & y);
            3'd3:    return x ^ y;
            3'd4:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        dout  = '0;
        dout1 = '0;
        for (int i = 0; i < 3; i++) begin
            dout[i]  = gf(fn[i], a, b);
            dout1[i] = gf(fn[i], a1, b1);
        end
    end

    gate_sweep_ctrl #(.HOLD_CYCLES(2), .N_IMPL(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .o_a(a), .o_b(b), .i_dut_out(dout),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err),
        .o_first_fail(ff), .o_fail_valid(fvalid)
    );

    gate_sweep_ctrl #(.HOLD_CYCLES(1), .N_IMPL(3)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .o_a(a1), .o_b(b1), .i_dut_out(dout1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1),
        .o_first_fail(ff1), .o_fail_valid(fvalid1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first SETTLE cycle.
    task automatic go(input logic [1:0] o);
        op    = o;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int cyc);
        cyc = 0;
        while (!done && cyc < lim) begin
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        for (int i = 0; i < 3; i++) fn[i] = 3'd0;
        #12;
        chk("rst_ab",     {a, b},  0);
        chk("rst_busy",   busy,    0);
        chk("rst_done",   done,    0);
        chk("rst_pass",   pass,    0);
        chk("rst_err",    err,     0);
        chk("rst_ff",     ff,      0);
        chk("rst_fvalid", fvalid,  0);
        chk("rst_done1",  done1,   0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: correct NOR parts, vector order and hold length
        go(2'b00);
        for (int k = 0; k < 12; k++) begin
            chk("t1_ab", {a, b}, k / 3);
            if (k == 11) chk("t1_done_early", done, 0);
            tick();
        end
        chk("t1_done",   done,   1);
        chk("t1_pass",   pass,   1);
        chk("t1_err",    err,    0);
        chk("t1_fvalid", fvalid, 0);
        chk("t1_busy",   busy,   0);
        chk("t1_ab_end", {a, b}, 3);

        // 2: XNOR golden, impl 1 stuck at 0
        fn[0] = 3'd1; fn[1] = 3'd4; fn[2] = 3'd1;
        go(2'b01);
        wait_done(40, cyc);
        chk("t2_err",    err,    9'h010);
        chk("t2_ff",     ff,     0);
        chk("t2_fvalid", fvalid, 1);
        chk("t2_pass",   pass,   0);

        // 3: NOR golden, impl 2 is XNOR
        fn[0] = 3'd0; fn[1] = 3'd0; fn[2] = 3'd1;
        go(2'b00);
        wait_done(40, cyc);
        chk("t3_len",    cyc,    12);
        chk("t3_err",    err,    9'h040);
        chk("t3_ff",     ff,     3);
        chk("t3_fvalid", fvalid, 1);
        chk("t3_pass",   pass,   0);

        // 4: reset during the second vector's SETTLE wipes partial results
        fn[0] = 3'd0; fn[1] = 3'd4; fn[2] = 3'd0;
        go(2'b00);
        repeat (3) tick();
        chk("t4_ab_pre",  {a, b}, 1);
        chk("t4_err_pre", err,    9'h008);
        #2 rst = 1'b1;
        #1;
        chk("t4_ab",     {a, b}, 0);
        chk("t4_busy",   busy,   0);
        chk("t4_err",    err,    0);
        chk("t4_fvalid", fvalid, 0);
        chk("t4_done",   done,   0);
        #2 rst = 1'b0;
        fn[1] = 3'd0;
        tick();
        go(2'b00);
        wait_done(40, cyc);
        chk("t4_pass", pass, 1);
        chk("t4_err2", err,  0);

        // 5: mid-sweep start/op change ignored; restart from DONE clears counters
        fn[0] = 3'd5; fn[1] = 3'd2; fn[2] = 3'd2;
        go(2'b10);
        repeat (4) tick();
        op    = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_ab_mid",   {a, b}, 1);
        chk("t5_busy_mid", busy,   1);
        wait_done(40, cyc);
        chk("t5_err",    err,    9'h001);
        chk("t5_ff",     ff,     3);
        chk("t5_fvalid", fvalid, 1);
        chk("t5_pass",   pass,   0);
        go(2'b10);
        chk("t5r_err",    err,    0);
        chk("t5r_fvalid", fvalid, 0);
        chk("t5r_ff",     ff,     0);
        chk("t5r_done",   done,   0);
        chk("t5r_busy",   busy,   1);
        chk("t5r_ab",     {a, b}, 0);
        wait_done(40, cyc);

        // 6: HOLD_CYCLES=1, XOR golden, impl 0 inverted
        fn[0] = 3'd1; fn[1] = 3'd3; fn[2] = 3'd3;
        go(2'b11);
        for (int k = 0; k < 8; k++) begin
            chk("t6_ab", {a1, b1}, k / 2);
            if (k == 7) chk("t6_done_early", done1, 0);
            tick();
        end
        chk("t6_done",   done1,   1);
        chk("t6_err",    err1,    9'h004);
        chk("t6_ff",     ff1,     0);
        chk("t6_fvalid", fvalid1, 1);
        chk("t6_pass",   pass1,   0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
